// File: rtl/msfsm_env_pkg.sv
// Shared types and constants for the toggle-controller environment driver.
// Event bits are ordered so that {phase, minus} directly indexes the expected event.
package msfsm_env_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SEND_P = 3'd1,
      WAIT_P = 3'd2,
      SEND_M = 3'd3,
      WAIT_M = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } state_e;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_TIMEOUT = 3'd1;
   localparam logic [2:0] ERR_WRONG   = 3'd2;
   localparam logic [2:0] ERR_MULTI   = 3'd3;
   localparam logic [2:0] ERR_IDLE    = 3'd4;

   localparam int NUM_EVT   = 4;
   localparam int EVT_RO1_P = 0;
   localparam int EVT_RO1_M = 1;
   localparam int EVT_RO2_P = 2;
   localparam int EVT_RO2_M = 3;

   function automatic logic [NUM_EVT-1:0] expected_evt(input logic phase, input logic minus);
      logic [NUM_EVT-1:0] v;
      v = {NUM_EVT{1'b0}};
      v[{phase, minus}] = 1'b1;
      return v;
   endfunction

   function automatic logic multi_hot(input logic [NUM_EVT-1:0] v);
      return (v & (v - 4'd1)) != 4'd0;
   endfunction

endpackage

// File: rtl/msfsm_toggle_env_driver_if.sv
// Control, status and event-pulse bundle between the environment driver and its users.
interface msfsm_toggle_env_driver_if #(parameter int CNT_W = 16);

   logic             start;
   logic [CNT_W-1:0] n_periods;
   logic             Ri_PLUS;
   logic             Ri_MINUS;
   logic             Ro1_PLUS;
   logic             Ro1_MINUS;
   logic             Ro2_PLUS;
   logic             Ro2_MINUS;
   logic             busy;
   logic             done;
   logic             error;
   logic [2:0]       err_code;
   logic [CNT_W-1:0] periods_done;

   modport master (
      input  start, n_periods, Ro1_PLUS, Ro1_MINUS, Ro2_PLUS, Ro2_MINUS,
      output Ri_PLUS, Ri_MINUS, busy, done, error, err_code, periods_done
   );

   modport slave (
      output start, n_periods, Ro1_PLUS, Ro1_MINUS, Ro2_PLUS, Ro2_MINUS,
      input  Ri_PLUS, Ri_MINUS, busy, done, error, err_code, periods_done
   );

endinterface

// File: rtl/msfsm_evt_watchdog.sv
// Cycle watchdog: cleared on each Ri pulse, counts wait cycles, flags when the
// next wait cycle would reach TMO_CYC.
module msfsm_evt_watchdog #(
   parameter int TMO_W   = 8,
   parameter int TMO_CYC = 200
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [TMO_W:0] LIMIT = (TMO_W + 1)'(TMO_CYC);

   logic [TMO_W-1:0] cnt_q;
   logic [TMO_W-1:0] cnt_d;

   assign expired_o = enable_i && (({1'b0, cnt_q} + {{TMO_W{1'b0}}, 1'b1}) == LIMIT);

   // Holding at expiry keeps the counter from wrapping back into range.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = {TMO_W{1'b0}};
      end else if (enable_i && !expired_o) begin
         cnt_d = cnt_q + TMO_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= {TMO_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/msfsm_toggle_env_driver.sv
// Environment driver for the decomposed toggle controller: emits Ri+/Ri- pulses and
// checks that Ro1/Ro2 events return in toggle order, flagging the first violation.
module msfsm_toggle_env_driver
   import msfsm_env_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int TMO_W   = 8,
   parameter int TMO_CYC = 200
) (
   input logic                      clk,
   input logic                      reset,
   msfsm_toggle_env_driver_if.master bus
);

   state_e             state_q, state_d;
   logic               phase_q, phase_d;
   logic [CNT_W-1:0]   n_lat_q, n_lat_d;
   logic [CNT_W-1:0]   pd_q, pd_d;
   logic               ri_plus_q, ri_plus_d;
   logic               ri_minus_q, ri_minus_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic [2:0]         err_code_q, err_code_d;

   logic [NUM_EVT-1:0] ro_s;
   logic [NUM_EVT-1:0] exp_s;
   logic               minus_s;
   logic [CNT_W-1:0]   pd_inc_s;
   logic               wd_clear_s;
   logic               wd_enable_s;
   logic               wd_expired_s;

   msfsm_evt_watchdog #(.TMO_W(TMO_W), .TMO_CYC(TMO_CYC)) u_wdog (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (wd_clear_s),
      .enable_i  (wd_enable_s),
      .expired_o (wd_expired_s)
   );

   assign bus.Ri_PLUS      = ri_plus_q;
   assign bus.Ri_MINUS     = ri_minus_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.error        = error_q;
   assign bus.err_code     = err_code_q;
   assign bus.periods_done = pd_q;

   // Next state, event checking and registered-output decode.
   always_comb begin
      ro_s            = {NUM_EVT{1'b0}};
      ro_s[EVT_RO1_P] = bus.Ro1_PLUS;
      ro_s[EVT_RO1_M] = bus.Ro1_MINUS;
      ro_s[EVT_RO2_P] = bus.Ro2_PLUS;
      ro_s[EVT_RO2_M] = bus.Ro2_MINUS;
      minus_s         = (state_q == SEND_M) || (state_q == WAIT_M);
      exp_s           = expected_evt(phase_q, minus_s);
      pd_inc_s        = (pd_q == {CNT_W{1'b1}}) ? pd_q : pd_q + CNT_W'(1);
      state_d         = state_q;
      phase_d         = phase_q;
      n_lat_d         = n_lat_q;
      pd_d            = pd_q;
      err_code_d      = err_code_q;
      wd_clear_s      = 1'b0;
      wd_enable_s     = 1'b0;
      case (state_q)
         IDLE, DONE, ERR: begin
            if ((state_q != ERR) && (ro_s != {NUM_EVT{1'b0}})) begin
               state_d    = ERR;
               err_code_d = multi_hot(ro_s) ? ERR_MULTI : ERR_IDLE;
            end else if (bus.start) begin
               state_d    = (bus.n_periods == {CNT_W{1'b0}}) ? DONE : SEND_P;
               phase_d    = 1'b0;
               n_lat_d    = bus.n_periods;
               pd_d       = {CNT_W{1'b0}};
               err_code_d = ERR_NONE;
            end else begin
               state_d = state_q;
            end
         end
         SEND_P, WAIT_P, SEND_M, WAIT_M: begin
            wd_clear_s  = (state_q == SEND_P) || (state_q == SEND_M);
            wd_enable_s = !wd_clear_s;
            if (multi_hot(ro_s)) begin
               state_d    = ERR;
               err_code_d = ERR_MULTI;
            end else if (ro_s == exp_s) begin
               if (!minus_s) begin
                  state_d = SEND_M;
               end else if (!phase_q) begin
                  phase_d = 1'b1;
                  state_d = SEND_P;
               end else begin
                  phase_d = 1'b0;
                  pd_d    = pd_inc_s;
                  state_d = (pd_inc_s == n_lat_q) ? DONE : SEND_P;
               end
            end else if (ro_s != {NUM_EVT{1'b0}}) begin
               state_d    = ERR;
               err_code_d = ERR_WRONG;
            end else if (wd_clear_s) begin
               state_d = minus_s ? WAIT_M : WAIT_P;
            end else if (wd_expired_s) begin
               state_d    = ERR;
               err_code_d = ERR_TIMEOUT;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      ri_plus_d  = (state_d == SEND_P);
      ri_minus_d = (state_d == SEND_M);
      busy_d     = (state_d == SEND_P) || (state_d == WAIT_P) ||
                   (state_d == SEND_M) || (state_d == WAIT_M);
      done_d     = (state_d == DONE);
      error_d    = (state_d == ERR);
   end

   // State and output registers; reset wins over any in-flight activity.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         phase_q    <= 1'b0;
         n_lat_q    <= {CNT_W{1'b0}};
         pd_q       <= {CNT_W{1'b0}};
         ri_plus_q  <= 1'b0;
         ri_minus_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         n_lat_q    <= n_lat_d;
         pd_q       <= pd_d;
         ri_plus_q  <= ri_plus_d;
         ri_minus_q <= ri_minus_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
      end
   end

endmodule

// File: tb/tb_msfsm_toggle_env_driver.sv
// Directed bench for msfsm_toggle_env_driver with a cycle-stepped responder model
// of the toggle controller (ideal or deliberately faulty).
module tb_msfsm_toggle_env_driver;

   localparam int CNT_W = 16;
   localparam int TMO_W = 8;
   localparam int TMO   = 20;

   localparam int M_IDEAL  = 0;
   localparam int M_WRONG  = 1;
   localparam int M_SILENT = 2;
   localparam int M_MULTI  = 3;
   localparam int M_OFF    = 4;

   logic clk = 1'b0;
   logic reset;

   msfsm_toggle_env_driver_if #(.CNT_W(CNT_W)) bus();

   msfsm_toggle_env_driver #(.CNT_W(CNT_W), .TMO_W(TMO_W), .TMO_CYC(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int mode;
   int cyc = 0;
   int ri_cnt, ro_cnt, last_ri, min_gap, max_gap;
   logic [1:0] ri_prev;
   logic rsp_phase;

   // One clock: responder echoes the Ri seen last cycle, then Ri pulses are logged.
   task automatic step();
      @(negedge clk);
      cyc++;
      bus.Ro1_PLUS  = 1'b0;
      bus.Ro1_MINUS = 1'b0;
      bus.Ro2_PLUS  = 1'b0;
      bus.Ro2_MINUS = 1'b0;
      if (ri_prev[0]) begin
         case (mode)
            M_IDEAL, M_SILENT: if (rsp_phase) bus.Ro2_PLUS = 1'b1; else bus.Ro1_PLUS = 1'b1;
            M_WRONG: bus.Ro2_PLUS = 1'b1;
            M_MULTI: begin bus.Ro1_PLUS = 1'b1; bus.Ro1_MINUS = 1'b1; end
            default: ;
         endcase
      end else if (ri_prev[1] && mode == M_IDEAL) begin
         if (rsp_phase) bus.Ro2_MINUS = 1'b1; else bus.Ro1_MINUS = 1'b1;
         rsp_phase = ~rsp_phase;
      end
      ro_cnt += int'(bus.Ro1_PLUS) + int'(bus.Ro1_MINUS) + int'(bus.Ro2_PLUS) + int'(bus.Ro2_MINUS);
      ri_prev = {bus.Ri_MINUS, bus.Ri_PLUS};
      if (bus.Ri_PLUS || bus.Ri_MINUS) begin
         ri_cnt++;
         if (last_ri >= 0) begin
            if (cyc - last_ri < min_gap) min_gap = cyc - last_ri;
            if (cyc - last_ri > max_gap) max_gap = cyc - last_ri;
         end
         last_ri = cyc;
      end
   endtask

   task automatic rsp_reset(input int m);
      mode = m; ri_prev = 2'b00; rsp_phase = 1'b0;
      ri_cnt = 0; ro_cnt = 0; last_ri = -1; min_gap = 1000; max_gap = 0;
   endtask

   task automatic do_start(input logic [CNT_W-1:0] n);
      bus.n_periods = n;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic run_to_end(input int budget);
      for (int i = 0; i < budget && !(bus.done || bus.error); i++) step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", bus.busy, bus.done); end
      checks++; if (bus.error !== 1'b0 || bus.err_code !== 3'd0) begin errors++; $display("FAIL reset_error got %b/%0d want 0/0", bus.error, bus.err_code); end
      checks++; if (bus.periods_done !== 16'd0) begin errors++; $display("FAIL reset_periods got %0d want 0", bus.periods_done); end
      step();
      checks++; if (bus.Ri_PLUS !== 1'b0 || bus.Ri_MINUS !== 1'b0) begin errors++; $display("FAIL reset_ri got %b%b want 00", bus.Ri_PLUS, bus.Ri_MINUS); end
   endtask

   task automatic test_idle_stray();
      rsp_reset(M_OFF);
      step();
      bus.Ro1_PLUS = 1'b1;
      step();
      checks++; if (bus.error !== 1'b1 || bus.err_code !== 3'd4) begin errors++; $display("FAIL idle_stray got %b/%0d want 1/4", bus.error, bus.err_code); end
      bus.Ro2_MINUS = 1'b1;
      step();
      checks++; if (bus.error !== 1'b1 || bus.err_code !== 3'd4) begin errors++; $display("FAIL err_ignores_events got %b/%0d want 1/4", bus.error, bus.err_code); end
   endtask

   task automatic test_zero_and_busy();
      rsp_reset(M_IDEAL);
      do_start(16'd0);
      checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL zero_done got done=%b busy=%b want 1/0", bus.done, bus.busy); end
      checks++; if (bus.error !== 1'b0 || bus.err_code !== 3'd0) begin errors++; $display("FAIL zero_clears_err got %b/%0d want 0/0", bus.error, bus.err_code); end
      step();
      checks++; if (ri_cnt !== 0) begin errors++; $display("FAIL zero_no_ri got %0d want 0", ri_cnt); end
      rsp_reset(M_IDEAL);
      do_start(16'd2);
      bus.n_periods = 16'd7;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      run_to_end(100);
      checks++; if (bus.done !== 1'b1 || bus.periods_done !== 16'd2) begin errors++; $display("FAIL busy_start_ignored got done=%b periods=%0d want 1/2", bus.done, bus.periods_done); end
      checks++; if (ri_cnt !== 8) begin errors++; $display("FAIL busy_start_ri got %0d want 8", ri_cnt); end
   endtask

   task automatic test_ideal();
      rsp_reset(M_IDEAL);
      do_start(16'd3);
      checks++; if (bus.busy !== 1'b1 || bus.Ri_PLUS !== 1'b1) begin errors++; $display("FAIL ideal_first got busy=%b ri+=%b want 1/1", bus.busy, bus.Ri_PLUS); end
      run_to_end(100);
      checks++; if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL ideal_end got d/e/b=%b%b%b want 100", bus.done, bus.error, bus.busy); end
      checks++; if (bus.periods_done !== 16'd3) begin errors++; $display("FAIL ideal_periods got %0d want 3", bus.periods_done); end
      checks++; if (ri_cnt + ro_cnt !== 24) begin errors++; $display("FAIL ideal_events got %0d want 24", ri_cnt + ro_cnt); end
      checks++; if (min_gap !== 2 || max_gap !== 2) begin errors++; $display("FAIL ideal_spacing got %0d..%0d want 2..2", min_gap, max_gap); end
   endtask

   task automatic test_wrong_event();
      rsp_reset(M_WRONG);
      do_start(16'd2);
      step();
      checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL wrong_early got %b want 0", bus.error); end
      step();
      checks++; if (bus.error !== 1'b1 || bus.err_code !== 3'd2 || bus.busy !== 1'b0) begin errors++; $display("FAIL wrong_event got e=%b code=%0d busy=%b want 1/2/0", bus.error, bus.err_code, bus.busy); end
      for (int i = 0; i < 10; i++) step();
      checks++; if (ri_cnt !== 1 || bus.done !== 1'b0) begin errors++; $display("FAIL wrong_no_more_ri got ri=%0d done=%b want 1/0", ri_cnt, bus.done); end
   endtask

   task automatic test_timeout();
      int t_m, t_e;
      rsp_reset(M_SILENT);
      t_m = -1; t_e = -1;
      do_start(16'd1);
      for (int i = 0; i < 10 && t_m < 0; i++) begin
         if (bus.Ri_MINUS) t_m = cyc; else step();
      end
      for (int i = 0; i < 100 && t_e < 0; i++) begin
         if (bus.error) t_e = cyc; else step();
      end
      checks++; if (t_m < 0 || t_e - t_m !== TMO + 1) begin errors++; $display("FAIL timeout_latency got %0d want %0d", t_e - t_m, TMO + 1); end
      checks++; if (bus.err_code !== 3'd1) begin errors++; $display("FAIL timeout_code got %0d want 1", bus.err_code); end
   endtask

   task automatic test_multi();
      rsp_reset(M_MULTI);
      do_start(16'd1);
      run_to_end(10);
      checks++; if (bus.error !== 1'b1 || bus.err_code !== 3'd3) begin errors++; $display("FAIL multi_event got %b/%0d want 1/3", bus.error, bus.err_code); end
   endtask

   task automatic test_reset_mid();
      rsp_reset(M_IDEAL);
      do_start(16'd5);
      step(); step();
      checks++; if (bus.Ri_MINUS !== 1'b1) begin errors++; $display("FAIL mid_ri_minus got %b want 1", bus.Ri_MINUS); end
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if ({bus.Ri_PLUS, bus.Ri_MINUS, bus.busy, bus.done, bus.error, bus.err_code, bus.periods_done} !== 24'd0) begin
         errors++; $display("FAIL mid_reset_outputs got ri=%b%b b=%b d=%b e=%b c=%0d p=%0d want all 0", bus.Ri_PLUS, bus.Ri_MINUS, bus.busy, bus.done, bus.error, bus.err_code, bus.periods_done);
      end
      step();
      checks++; if (bus.busy !== 1'b0 || bus.Ri_PLUS !== 1'b0 || bus.error !== 1'b0) begin errors++; $display("FAIL mid_reset_idle got b=%b ri+=%b e=%b want 000", bus.busy, bus.Ri_PLUS, bus.error); end
      rsp_reset(M_IDEAL);
      do_start(16'd5);
      run_to_end(200);
      checks++; if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.periods_done !== 16'd5) begin errors++; $display("FAIL mid_rerun got d=%b e=%b p=%0d want 1/0/5", bus.done, bus.error, bus.periods_done); end
      checks++; if (ri_cnt !== 20) begin errors++; $display("FAIL mid_rerun_ri got %0d want 20", ri_cnt); end
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0;
      bus.n_periods = '0;
      bus.Ro1_PLUS = 1'b0; bus.Ro1_MINUS = 1'b0;
      bus.Ro2_PLUS = 1'b0; bus.Ro2_MINUS = 1'b0;
      rsp_reset(M_OFF);
      test_reset();
      test_idle_stray();
      test_zero_and_busy();
      test_ideal();
      test_wrong_event();
      test_timeout();
      test_multi();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
